// File: rtl/gen2_pkg.sv
// Shared EPC Gen2 definitions: command encodings, opcodes, frame lengths and CRC-5 constants.
package gen2_pkg;

  typedef enum logic [2:0] {
    CMD_QUERYREP = 3'd0,
    CMD_ACK      = 3'd1,
    CMD_QUERY    = 3'd2,
    CMD_QUERYADJ = 3'd3,
    CMD_UNSUP    = 3'd7
  } cmd_type_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_OP,
    S_BODY,
    S_HOLD
  } framer_state_e;

  localparam logic [1:0] OP_QUERYREP = 2'b00;
  localparam logic [1:0] OP_ACK      = 2'b01;
  localparam logic [3:0] OP_QUERY    = 4'b1000;
  localparam logic [3:0] OP_QUERYADJ = 4'b1001;

  // Total frame lengths in bits, opcode included.
  localparam logic [5:0] LEN_QUERYREP = 6'd4;
  localparam logic [5:0] LEN_ACK      = 6'd18;
  localparam logic [5:0] LEN_QUERY    = 6'd22;
  localparam logic [5:0] LEN_QUERYADJ = 6'd9;

  // Last Query bit that lands in payload; the five CRC bits follow it.
  localparam logic [5:0] QUERY_PARAM_END = 6'd17;
  localparam logic [5:0] BIT_COUNT_MAX   = 6'd63;

  localparam logic [4:0] CRC5_PRESET = 5'b01001;
  localparam logic [4:0] CRC5_POLY   = 5'b01001;

  function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic b,
                                           input logic [4:0] poly);
    logic fb;
    fb = crc[4] ^ b;
    return {crc[3:0], 1'b0} ^ (fb ? poly : 5'b00000);
  endfunction

endpackage

// File: rtl/crc5_serial.sv
// Bit-serial CRC-5 register; clear loads the preset and wins over enable.
module crc5_serial
  import gen2_pkg::*;
#(
  parameter logic [4:0] PRESET = 5'b01001,
  parameter logic [4:0] POLY   = 5'b01001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       bit_in,
  output logic [4:0] crc
);

  logic [4:0] crc_q;
  logic [4:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = PRESET;
    end else if (en) begin
      crc_d = crc5_step(crc_q, bit_in, POLY);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= PRESET;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/gen2_cmd_framer.sv
// Frames Gen2 reader commands from the PIE receiver bit stream and reports one
// decoded command (or an error) per frame as a single-cycle pulse.
module gen2_cmd_framer
  import gen2_pkg::*;
#(
  parameter int         PAYLOAD_W   = 16,
  parameter logic [4:0] CRC5_PRESET = gen2_pkg::CRC5_PRESET,
  parameter logic [4:0] CRC5_POLY   = gen2_pkg::CRC5_POLY
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_start,
  input  logic                 bitin,
  input  logic                 bitclk,
  output logic                 cmd_valid,
  output logic                 cmd_err,
  output logic [2:0]           cmd_type,
  output logic [PAYLOAD_W-1:0] payload,
  output logic [5:0]           bit_count
);

  framer_state_e        state_q, state_d;
  cmd_type_e            cmd_type_q, cmd_type_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [5:0]           bit_count_q, bit_count_d;
  logic [5:0]           len_q, len_d;
  logic [3:0]           op_q, op_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic                 cmd_err_q, cmd_err_d;
  logic                 bitclk_q;
  logic                 bit_ev;
  logic                 crc_en;
  logic [4:0]           crc_q;
  logic [4:0]           crc_next;

  assign bit_ev = bitclk & ~bitclk_q;
  assign crc_en = bit_ev & ~frame_start & (state_q != S_HOLD);
  // Residue including the bit arriving this cycle, so completion needs no extra clk.
  assign crc_next = crc5_step(crc_q, bitin, CRC5_POLY);

  crc5_serial #(
    .PRESET(CRC5_PRESET),
    .POLY  (CRC5_POLY)
  ) u_crc (
    .clk   (clk),
    .rst   (reset),
    .en    (crc_en),
    .clr   (frame_start),
    .bit_in(bitin),
    .crc   (crc_q)
  );

  always_comb begin
    state_d     = state_q;
    cmd_type_d  = cmd_type_q;
    payload_d   = payload_q;
    bit_count_d = bit_count_q;
    len_d       = len_q;
    op_d        = op_q;
    cmd_valid_d = 1'b0;
    cmd_err_d   = 1'b0;
    if (frame_start) begin
      state_d     = S_IDLE;
      cmd_type_d  = CMD_QUERYREP;
      payload_d   = '0;
      bit_count_d = '0;
      len_d       = '0;
      op_d        = '0;
    end else if (bit_ev) begin
      if (bit_count_q != BIT_COUNT_MAX) begin
        bit_count_d = bit_count_q + 6'd1;
      end
      case (state_q)
        S_IDLE: begin
          op_d    = {op_q[2:0], bitin};
          state_d = S_OP;
        end
        S_OP: begin
          op_d = {op_q[2:0], bitin};
          if (bit_count_d == 6'd2 && !op_d[1]) begin
            state_d = S_BODY;
            if (op_d[1:0] == OP_QUERYREP) begin
              cmd_type_d = CMD_QUERYREP;
              len_d      = LEN_QUERYREP;
            end else begin
              cmd_type_d = CMD_ACK;
              len_d      = LEN_ACK;
            end
          end else if (bit_count_d == 6'd4) begin
            if (op_d == OP_QUERY) begin
              cmd_type_d = CMD_QUERY;
              len_d      = LEN_QUERY;
              state_d    = S_BODY;
            end else if (op_d == OP_QUERYADJ) begin
              cmd_type_d = CMD_QUERYADJ;
              len_d      = LEN_QUERYADJ;
              state_d    = S_BODY;
            end else begin
              cmd_type_d = CMD_UNSUP;
              cmd_err_d  = 1'b1;
              state_d    = S_HOLD;
            end
          end
        end
        S_BODY: begin
          if (cmd_type_q != CMD_QUERY || bit_count_d <= QUERY_PARAM_END) begin
            payload_d = {payload_q[PAYLOAD_W-2:0], bitin};
          end
          if (bit_count_d == len_q) begin
            state_d = S_HOLD;
            if (cmd_type_q == CMD_QUERY && crc_next != 5'b00000) begin
              cmd_err_d = 1'b1;
            end else begin
              cmd_valid_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cmd_type_q  <= CMD_QUERYREP;
      payload_q   <= '0;
      bit_count_q <= '0;
      len_q       <= '0;
      op_q        <= '0;
      cmd_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      bitclk_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_type_q  <= cmd_type_d;
      payload_q   <= payload_d;
      bit_count_q <= bit_count_d;
      len_q       <= len_d;
      op_q        <= op_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_err_q   <= cmd_err_d;
      bitclk_q    <= bitclk;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_err   = cmd_err_q;
  assign cmd_type  = cmd_type_q;
  assign payload   = payload_q;
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_gen2_cmd_framer.sv
// Randomized and directed frames for gen2_cmd_framer, scored against a field-level
// model of the Gen2 command formats.
module tb_gen2_cmd_framer;

  localparam int W = 20;  // {err, type[2:0], payload[15:0]}

  logic        clk;
  logic        reset;
  logic        frame_start;
  logic        bitin;
  logic        bitclk;
  logic        cmd_valid;
  logic        cmd_err;
  logic [2:0]  cmd_type;
  logic [15:0] payload;
  logic [5:0]  bit_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int both_cnt = 0;
  int last_rise_cyc = 0;
  bit fs_with_bit = 1'b0;

  logic         frm[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int           exp_cyc_q[$];
  int           obs_cyc_q[$];

  gen2_cmd_framer #(.PAYLOAD_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .bitin      (bitin),
    .bitclk     (bitclk),
    .cmd_valid  (cmd_valid),
    .cmd_err    (cmd_err),
    .cmd_type   (cmd_type),
    .payload    (payload),
    .bit_count  (bit_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL timeout: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  // pulse monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (cmd_valid && cmd_err) both_cnt++;
      if (cmd_valid || cmd_err) begin
        obs_q.push_back({cmd_err, cmd_type, payload});
        obs_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic logic [4:0] ref_crc17();
    logic [4:0] c;
    logic fb;
    c = 5'b01001;
    for (int i = 0; i < 17; i++) begin
      fb = c[4] ^ frm[i];
      c = {c[3:0], 1'b0} ^ (fb ? 5'b01001 : 5'b00000);
    end
    return c;
  endfunction

  function automatic void model(input int n, output bit hp, output int pidx,
                                output logic [W-1:0] rec);
    int op_len, len, fend;
    logic [2:0] t;
    logic [15:0] val;
    logic e;
    logic [3:0] code;
    logic [4:0] rx_crc;
    code = {frm[0], frm[1], frm[2], frm[3]};
    if (!frm[0]) begin
      op_len = 2;
      t = frm[1] ? 3'd1 : 3'd0;
      len = frm[1] ? 18 : 4;
    end else begin
      op_len = 4;
      if (code == 4'b1000) begin t = 3'd2; len = 22; end
      else if (code == 4'b1001) begin t = 3'd3; len = 9; end
      else begin t = 3'd7; len = 4; end
    end
    val = 16'h0;
    e = 1'b0;
    if (t == 3'd7) begin
      e = 1'b1;
    end else begin
      fend = (t == 3'd2) ? 17 : len;
      for (int i = op_len; i < fend; i++) val = {val[14:0], frm[i]};
      if (t == 3'd2) begin
        rx_crc = {frm[17], frm[18], frm[19], frm[20], frm[21]};
        e = (rx_crc != ref_crc17());
      end
    end
    rec = {e, t, val};
    pidx = len - 1;
    hp = (n >= len);
  endfunction

  // frame construction
  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) frm.push_back(v[i]);
  endtask

  task automatic build(input int kind, input bit bad_crc);
    logic [4:0] c;
    int idx;
    int code;
    frm.delete();
    case (kind)
      0: begin push_bits(32'b00, 2); push_bits($urandom_range(0, 3), 2); end
      1: begin push_bits(32'b01, 2); push_bits($urandom_range(0, 65535), 16); end
      2: begin
        push_bits(32'b1000, 4);
        push_bits($urandom_range(0, 8191), 13);
        c = ref_crc17();
        if (bad_crc) begin
          idx = int'($urandom_range(0, 4));
          c[idx] = ~c[idx];
        end
        push_bits({27'b0, c}, 5);
      end
      3: begin push_bits(32'b1001, 4); push_bits($urandom_range(0, 31), 5); end
      default: begin
        do code = int'($urandom_range(8, 15)); while (code == 8 || code == 9);
        push_bits(32'(code), 4);
        push_bits($urandom_range(0, 15), 4);
      end
    endcase
  endtask

  // drivers
  task automatic pulse_fs(input string tag);
    @(negedge clk);
    frame_start = 1'b1;
    if (fs_with_bit) begin
      bitin = 1'b1;
      bitclk = 1'b1;
    end
    @(negedge clk);
    frame_start = 1'b0;
    bitclk = 1'b0;
    chk({tag, "_fs_bc"}, 32'(bit_count), 32'd0);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    bitin = b;
    bitclk = 1'b1;
    last_rise_cyc = cyc;
    repeat ($urandom_range(1, 2)) @(negedge clk);
    bitclk = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // scoreboard
  task automatic check_pulses(input string tag);
    chk({tag, "_npulse"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      chk({tag, "_rec"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
      chk({tag, "_lat"}, 32'(obs_cyc_q.pop_front()), 32'(exp_cyc_q.pop_front()));
    end
    exp_q.delete();
    obs_q.delete();
    exp_cyc_q.delete();
    obs_cyc_q.delete();
  endtask

  task automatic run_frame(input int n, input string tag);
    bit hp;
    int pidx;
    int pcyc;
    logic [W-1:0] rec;
    pulse_fs(tag);
    model(n, hp, pidx, rec);
    pcyc = -10;
    for (int i = 0; i < n; i++) begin
      send_bit(frm[i]);
      if (i == pidx) pcyc = last_rise_cyc;
    end
    if (hp) begin
      exp_q.push_back(rec);
      exp_cyc_q.push_back(pcyc + 1);
    end
    repeat (3) @(negedge clk);
    check_pulses(tag);
    if (hp) begin
      chk({tag, "_type_hold"}, 32'(cmd_type), 32'(rec[18:16]));
      chk({tag, "_pl_hold"}, 32'(payload), 32'(rec[15:0]));
    end
    chk({tag, "_bc"}, 32'(bit_count), 32'((n > 63) ? 63 : n));
  endtask

  initial begin
    bit hp;
    int pidx, n, kind;
    logic [W-1:0] rec;

    reset = 1'b1;
    frame_start = 1'b0;
    bitin = 1'b0;
    bitclk = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_err", 32'(cmd_err), 32'd0);
    chk("rst_type", 32'(cmd_type), 32'd0);
    chk("rst_payload", 32'(payload), 32'd0);
    chk("rst_bc", 32'(bit_count), 32'd0);

    // Query, good and bad CRC
    frm.delete();
    push_bits(32'b1000_0_00_1_00_00_0_0000_10011, 22);
    run_frame(22, "query_ok");
    chk("query_ok_pl", 32'(payload), 32'h0200);
    frm.delete();
    push_bits(32'b1000_0_00_1_00_00_0_0000_10010, 22);
    run_frame(22, "query_bad");
    chk("query_bad_type", 32'(cmd_type), 32'd2);

    // ACK followed by ignored bits
    frm.delete();
    push_bits(32'b01, 2);
    push_bits(32'hA5C3, 16);
    push_bits(32'b10110, 5);
    run_frame(23, "ack");
    chk("ack_pl", 32'(payload), 32'hA5C3);
    chk("ack_type", 32'(cmd_type), 32'd1);

    // QueryRep then QueryAdjust
    frm.delete();
    push_bits(32'b0011, 4);
    run_frame(4, "qrep");
    chk("qrep_pl", 32'(payload), 32'h0003);
    frm.delete();
    push_bits(32'b1001_10_110, 9);
    run_frame(9, "qadj");
    chk("qadj_pl", 32'(payload), 32'h0016);
    chk("qadj_type", 32'(cmd_type), 32'd3);

    // unsupported opcode
    frm.delete();
    push_bits(32'b1100_0101, 8);
    run_frame(8, "unsup");
    chk("unsup_type", 32'(cmd_type), 32'd7);

    // ACK aborted after 10 bits
    build(1, 1'b0);
    run_frame(10, "abort");
    pulse_fs("abort2");
    chk("abort_type", 32'(cmd_type), 32'd0);
    chk("abort_pl", 32'(payload), 32'd0);

    // bit event coincident with frame_start is discarded
    fs_with_bit = 1'b1;
    frm.delete();
    push_bits(32'b0010, 4);
    run_frame(4, "fs_same");
    chk("fs_same_pl", 32'(payload), 32'h0002);
    fs_with_bit = 1'b0;

    // bit_count saturation
    build(1, 1'b0);
    for (int i = 0; i < 52; i++) frm.push_back(1'($urandom_range(0, 1)));
    run_frame(70, "sat");

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      kind = int'($urandom_range(0, 4));
      build(kind, 1'($urandom_range(0, 1)));
      fs_with_bit = ($urandom_range(0, 3) == 0);
      model(frm.size(), hp, pidx, rec);
      if ($urandom_range(0, 5) == 0) begin
        n = int'($urandom_range(1, pidx));
      end else begin
        repeat ($urandom_range(0, 3)) frm.push_back(1'($urandom_range(0, 1)));
        n = frm.size();
      end
      run_frame(n, $sformatf("rnd%0d", f));
    end
    fs_with_bit = 1'b0;

    // async reset mid-Query
    build(2, 1'b0);
    pulse_fs("arst");
    for (int i = 0; i < 6; i++) send_bit(frm[i]);
    @(negedge clk);
    chk("arst_pre_type", 32'(cmd_type), 32'd2);
    chk("arst_pre_bc", 32'(bit_count), 32'd6);
    check_pulses("arst_pre");
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_type", 32'(cmd_type), 32'd0);
    chk("arst_bc", 32'(bit_count), 32'd0);
    chk("arst_pl", 32'(payload), 32'd0);
    chk("arst_valid", 32'(cmd_valid), 32'd0);
    chk("arst_err", 32'(cmd_err), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    build(2, 1'b0);
    run_frame(22, "post_rst");

    chk("excl", 32'(both_cnt), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
